lif_layer_param: RTL
====================

// Module: lif_layer_param
// PURPOSE
//  Parametrised leaky-integrate-and-fire layer: N_IN input neurons, each fed by its own IN_W-bit
//  drive, converge onto one output neuron that integrates weighted input spikes.
//  Adds to the fixed 3-neuron network:
//   - explicit leak
//   - refractory period
//   - saturating arithmetic
//   - step-enable strobe
//  Sits between top-level pad mapping and spike observation outputs.
// PARAMETERS
//  N_IN        3    number of input neurons (1..8)
//  IN_W        4    width of each external drive value
//  POT_W       8    membrane potential width (all neurons)
//  THRESH      100  fire threshold, 1 <= THRESH <= 2^POT_W-1 (all neurons)
//  LEAK_SHIFT  3    leak = pot >> LEAK_SHIFT per step (1..POT_W-1)
//  REFRAC      2    refractory steps after a spike (0..15)
//  OUT_WEIGHT  40   drive added to output neuron per input spike (< 2^POT_W)
// PORTS
//  clk        in   1           clock
//  reset      in   1           synchronous reset, active-high
//  step_en    in   1           advance all neurons one time step this cycle
//  ext_in     in   N_IN*IN_W   drive; neuron i uses ext_in[i*IN_W +: IN_W]
//  spike      out  N_IN        input-neuron spike pulses (registered)
//  spike_out  out  1           output-neuron spike pulse (registered)
//  pot_mon    out  POT_W       output-neuron membrane potential (registered)
//  spike_cnt  out  8           output spike count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (wins over step_en): all potentials 0, refractory counters 0; spike, spike_out,
//    pot_mon, spike_cnt = 0.
//  - step_en=0: potentials and refractory counters hold; spike and spike_out driven 0
//    (pulses last exactly one step).
//  - Per neuron, on an edge with step_en=1:
//     - refr>0: pot<=0, refr<=refr-1, spike<=0.
//     - else nxt = pot - (pot>>LEAK_SHIFT) + drive, computed in POT_W+1 bits, saturated to
//       2^POT_W-1.
//        - nxt >= THRESH: spike<=1, pot<=0, refr<=REFRAC.
//        - else pot<=nxt, spike<=0.
//  - Input neuron i drive = ext_in slice i, zero-extended.
//  - Output neuron drive = popcount(spike) * OUT_WEIGHT, using the registered spike vector from
//    the previous step, computed wide and saturated to 2^POT_W-1.
//  - Latency: ext_in sampled at step k -> spike at step k+1 edge -> spike_out no earlier than
//    the next enabled step.
//  - Spikes from several input neurons in the same step add; no arbitration.
//  - Reset mid-integration discards all accumulated charge and refractory state immediately.
//  - Steady drive d with no firing converges to the leak equilibrium; constant drive below the
//    equilibrium threshold never fires.
// CONFIGURATION
//  LIF_SPIKE_COUNT_EN defined:
//    - spike_cnt is an 8-bit counter, +1 on each edge where spike_out goes 1.
//    - Saturates at 255; cleared only by reset.
//  LIF_SPIKE_COUNT_EN undefined:
//    - No counter logic; spike_cnt tied to 8'd0.
// TESTING
//  1. Defaults, ext_in neuron0=15, others 0, step_en=1:
//     - pot0 = 15,29,41,51,60,68,75,81,86,91,95,99.
//     - spike[0]=1 after the 13th edge (nxt=102).
//     - pot0 then holds 0 for 2 steps, restarts 15,29...
//  2. All ext_in=0 for 50 steps after reset: no spike, no spike_out, pot_mon=0.
//  3. Neuron0 only firing (as in 1), single spikes spaced 15 steps:
//     - Output pot = 40, then leaks between spikes.
//     - No spike_out until accumulation >= 100.
//     - Check exact pot_mon sequence vs model.
//  4. All three neurons driven 15 from reset:
//     - All three spike on the same step (popcount 3 -> 120 >= 100).
//     - spike_out=1 on the next enabled edge.
//  5. step_en toggled 1,0,0,1 mid-run:
//     - Potentials unchanged while 0; spikes 0.
//     - Sequence resumes exactly.
//  6. Assert reset in refractory step: all state 0 next edge; with LIF_SPIKE_COUNT_EN:
//     - spike_cnt counts each spike_out, saturates at 255 under continuous firing.
//     - spike_cnt returns to 0 on reset.

Source files
------------

// File: rtl/lif_layer_param.sv
// lif_layer_param: N_IN leaky-integrate-and-fire input neurons feeding one output
// neuron through a popcount-weighted synapse. Each neuron has its own leak,
// saturation and refractory handling. Everything advances only on step_en cycles.
// Optional feature: define LIF_SPIKE_COUNT_EN to get a saturating 8-bit count of
// output spikes on spike_cnt; otherwise spike_cnt is tied to zero.
module lif_layer_param #(
   parameter int N_IN       = 3,
   parameter int IN_W       = 4,
   parameter int POT_W      = 8,
   parameter int THRESH     = 100,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRAC     = 2,
   parameter int OUT_WEIGHT = 40
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 step_en,
   input  logic [N_IN*IN_W-1:0] ext_in,
   output logic [N_IN-1:0]      spike,
   output logic                 spike_out,
   output logic [POT_W-1:0]     pot_mon,
   output logic [7:0]           spike_cnt
);

   localparam logic [POT_W:0]   SAT   = {1'b0, {POT_W{1'b1}}};
   localparam logic [POT_W-1:0] THR   = POT_W'(THRESH);
   localparam logic [3:0]       REF_N = 4'(REFRAC);
   localparam int               PW    = POT_W + 4;

   // Leak then add drive one bit wider than the potential, clipping at full scale.
   function automatic logic [POT_W-1:0] leak_add(input logic [POT_W-1:0] p,
                                                 input logic [POT_W-1:0] d);
      logic [POT_W:0] s;
      s = {1'b0, p - (p >> LEAK_SHIFT)} + {1'b0, d};
      return (s > SAT) ? SAT[POT_W-1:0] : s[POT_W-1:0];
   endfunction

   logic [POT_W-1:0] pot_in      [N_IN];
   logic [3:0]       refr_in     [N_IN];
   logic [POT_W-1:0] pot_in_nxt  [N_IN];
   logic [3:0]       refr_in_nxt [N_IN];
   logic [POT_W-1:0] nv_in;
   logic [N_IN-1:0]  spike_nxt;

   // Spike vector of the last enabled step; survives idle cycles so a spike
   // followed by step_en=0 still reaches the output neuron on the next step.
   logic [N_IN-1:0]  spike_prev;

   logic [3:0]       refr_out;
   logic [3:0]       refr_out_nxt;
   logic [POT_W-1:0] pot_out_nxt;
   logic [POT_W-1:0] nv_out;
   logic             spike_out_nxt;
   logic [3:0]       pc;
   logic [PW-1:0]    drive_wide;
   logic [POT_W-1:0] drive_out;

   // Next state of every input neuron: refractory countdown, else leak/integrate/fire.
   always_comb begin
      nv_in     = '0;
      spike_nxt = '0;
      for (int i = 0; i < N_IN; i++) begin
         pot_in_nxt[i]  = '0;
         refr_in_nxt[i] = '0;
         if (refr_in[i] != 4'd0) begin
            refr_in_nxt[i] = refr_in[i] - 4'd1;
         end else begin
            nv_in = leak_add(pot_in[i], POT_W'(ext_in[i*IN_W +: IN_W]));
            if (nv_in >= THR) begin
               refr_in_nxt[i] = REF_N;
               spike_nxt[i]   = 1'b1;
            end else begin
               pot_in_nxt[i] = nv_in;
            end
         end
      end
   end

   // Output neuron drive: weighted popcount of the previous step's spikes, clipped.
   always_comb begin
      pc = '0;
      for (int i = 0; i < N_IN; i++) begin
         pc = pc + 4'(spike_prev[i]);
      end
      drive_wide = PW'(pc) * PW'(OUT_WEIGHT);
      drive_out  = (drive_wide > PW'(SAT)) ? SAT[POT_W-1:0] : drive_wide[POT_W-1:0];
   end

   // Next state of the output neuron, same update rule as the inputs.
   always_comb begin
      pot_out_nxt   = '0;
      refr_out_nxt  = '0;
      spike_out_nxt = 1'b0;
      nv_out        = '0;
      if (refr_out != 4'd0) begin
         refr_out_nxt = refr_out - 4'd1;
      end else begin
         nv_out = leak_add(pot_mon, drive_out);
         if (nv_out >= THR) begin
            refr_out_nxt  = REF_N;
            spike_out_nxt = 1'b1;
         end else begin
            pot_out_nxt = nv_out;
         end
      end
   end

   // State registers; reset beats step_en, idle cycles hold state and clear pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_IN; i++) begin
            pot_in[i]  <= '0;
            refr_in[i] <= '0;
         end
         spike      <= '0;
         spike_prev <= '0;
         spike_out  <= 1'b0;
         pot_mon    <= '0;
         refr_out   <= '0;
      end else if (step_en) begin
         for (int i = 0; i < N_IN; i++) begin
            pot_in[i]  <= pot_in_nxt[i];
            refr_in[i] <= refr_in_nxt[i];
         end
         spike      <= spike_nxt;
         spike_prev <= spike_nxt;
         spike_out  <= spike_out_nxt;
         pot_mon    <= pot_out_nxt;
         refr_out   <= refr_out_nxt;
      end else begin
         spike     <= '0;
         spike_out <= 1'b0;
      end
   end

`ifdef LIF_SPIKE_COUNT_EN
   // Saturating count of output spikes, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         spike_cnt <= '0;
      end else if (step_en && spike_out_nxt && (spike_cnt != 8'hFF)) begin
         spike_cnt <= spike_cnt + 8'd1;
      end
   end
`else
   assign spike_cnt = 8'd0;
`endif

endmodule
